icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the multi-cycle RISC-V core's instruction request/response channels and the memory-side read bus.
- The core drives PC with Inst_Req_Valid and gets Instruction back with Inst_Valid; the protocol is identical to a bare memory.
- Misses refill a whole line as a fixed-length read burst.
- Also provides hit/miss counters for the core's perf-counter outputs.

---
 rtl/icache_dm_pkg.sv | 23 ++
 rtl/icache_dm_array.sv | 65 ++++++
 rtl/icache_dm.sv | 170 +++++++++++++++++
 tb/tb_icache_dm.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the default geometry, the one-hot FSM state encoding and the
// helper that derives the tag width from the geometry.
package icache_dm_pkg;

    localparam int ADDR_W    = 32;
    localparam int IDX_W_DEF = 3;   // 8 sets
    localparam int OFF_W_DEF = 4;   // 16-byte lines, 4 words

    // One-hot controller states
    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_LOOKUP   = 5'b00010,
        ST_MISS_REQ = 5'b00100,
        ST_REFILL   = 5'b01000,
        ST_RESP     = 5'b10000
    } state_t;

    function automatic int tag_width(input int idx_w, input int off_w);
        return ADDR_W - idx_w - off_w;
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Tag, data and valid storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst     clock, synchronous active-high reset (valid bits only)
//   clr_all      clears every valid bit (fence)
//   wr_en        one write enable per word of the line at wr_idx
//   wr_idx       set written by refill
//   wr_data      word written on any asserted wr_en
//   tag_we       writes tag_wdata to wr_idx and sets its valid bit
//   rd_idx       set read asynchronously
//   rd_word      word within the read line
//   rd_data      word at (rd_idx, rd_word)
//   rd_tag       tag at rd_idx
//   rd_valid     valid bit at rd_idx
module icache_dm_array #(
    parameter int IDX_W = 3,
    parameter int OFF_W = 4,
    parameter int TAG_W = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_all,
    input  logic [2**(OFF_W-2)-1:0] wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [31:0]            wr_data,
    input  logic                   tag_we,
    input  logic [TAG_W-1:0]       tag_wdata,
    input  logic [IDX_W-1:0]       rd_idx,
    input  logic [OFF_W-3:0]       rd_word,
    output logic [31:0]            rd_data,
    output logic [TAG_W-1:0]       rd_tag,
    output logic                   rd_valid
);

    localparam int SETS = 2**IDX_W;
    localparam int LW   = 2**(OFF_W-2);

    logic [31:0]      data_mem [SETS][LW];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid;

    // Storage itself carries no reset; only the valid bits matter after reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < LW; w++) begin
            if (wr_en[w]) begin
                data_mem[wr_idx][w] <= wr_data;
            end
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= tag_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_data  = data_mem[rd_idx][rd_word];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the core fetch channel
// and a burst read bus. Misses refill the whole line; hit/miss counters feed
// the core's perf counters.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   PC, Inst_Req_Valid, Inst_Req_Ack fetch request channel
//   Instruction, Inst_Valid, Inst_Ack fetch response channel
//   fence_i                          invalidate-all pulse
//   Mem_Req_Addr/Valid/Ready         line refill request
//   Mem_Rd_Data/Valid/Last/Ready     refill burst beats
//   hit_cnt, miss_cnt                lookup counters (wrap)
//   refill_err                       sticky burst-length error
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic        fence_i,
    output logic [31:0] Mem_Req_Addr,
    output logic        Mem_Req_Valid,
    input  logic        Mem_Req_Ready,
    input  logic [31:0] Mem_Rd_Data,
    input  logic        Mem_Rd_Valid,
    input  logic        Mem_Rd_Last,
    output logic        Mem_Rd_Ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic        refill_err
);

    localparam int TAG_W  = tag_width(IDX_W, OFF_W);
    localparam int WORD_W = OFF_W - 2;
    localparam int LW     = 2**WORD_W;

    state_t            state;
    logic [31:2]       req_addr;
    logic [WORD_W-1:0] beat;
    logic              fence_pend;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              fence_now;
    logic              hit;
    logic              beat_fire;
    logic              last_beat;
    logic [LW-1:0]     wr_en;
    logic [31:0]       arr_data;
    logic [TAG_W-1:0]  arr_tag;
    logic              arr_valid;
    logic              pc_unused;

    // Byte-offset bits of the fetch address play no part in the lookup.
    assign pc_unused = ^PC[1:0];

    assign req_tag  = req_addr[31:32-TAG_W];
    assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_word = req_addr[OFF_W-1:2];

    // A fence raised while busy is held until the controller is idle again,
    // so a line refilled by the in-flight fetch is still invalidated.
    assign fence_now = fence_i || fence_pend;

    assign Inst_Req_Ack  = !rst && (state == ST_IDLE) && !fence_now;
    assign Inst_Valid    = (state == ST_RESP);
    assign Mem_Req_Valid = (state == ST_MISS_REQ);
    assign Mem_Rd_Ready  = (state == ST_REFILL);

    assign hit       = arr_valid && (arr_tag == req_tag);
    assign beat_fire = (state == ST_REFILL) && Mem_Rd_Valid;
    assign last_beat = (beat == WORD_W'(LW-1));
    assign wr_en     = beat_fire ? (LW'(1) << beat) : '0;

    icache_dm_array #(
        .IDX_W (IDX_W),
        .OFF_W (OFF_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .clr_all   ((state == ST_IDLE) && fence_now),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_data   (Mem_Rd_Data),
        .tag_we    (beat_fire && last_beat),
        .tag_wdata (req_tag),
        .rd_idx    (req_idx),
        .rd_word   (req_word),
        .rd_data   (arr_data),
        .rd_tag    (arr_tag),
        .rd_valid  (arr_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            beat         <= '0;
            fence_pend   <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            refill_err   <= 1'b0;
            Instruction  <= '0;
            Mem_Req_Addr <= '0;
        end else begin
            if (state == ST_IDLE) begin
                fence_pend <= 1'b0;
            end else if (fence_i) begin
                fence_pend <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (Inst_Req_Valid && Inst_Req_Ack) begin
                        req_addr <= PC[31:2];
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        hit_cnt     <= hit_cnt + 32'd1;
                        Instruction <= arr_data;
                        state       <= ST_RESP;
                    end else begin
                        miss_cnt     <= miss_cnt + 32'd1;
                        Mem_Req_Addr <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        state        <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (Mem_Req_Ready) begin
                        beat  <= '0;
                        state <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (Mem_Rd_Valid) begin
                        beat <= beat + WORD_W'(1);
                        if (beat == req_word) begin
                            Instruction <= Mem_Rd_Data;
                        end
                        // Last is only checked; the beat count ends the burst.
                        if (Mem_Rd_Last != last_beat) begin
                            refill_err <= 1'b1;
                        end
                        if (last_beat) begin
                            beat  <= '0;
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (Inst_Ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized scoreboard bench for icache_dm with a memory responder,
// a core-side monitor and an abstract cache/memory reference model.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic        fence_i;
    logic [31:0] Mem_Req_Addr;
    logic        Mem_Req_Valid;
    logic        Mem_Req_Ready;
    logic [31:0] Mem_Rd_Data;
    logic        Mem_Rd_Valid;
    logic        Mem_Rd_Last;
    logic        Mem_Rd_Ready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        refill_err;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .Inst_Req_Valid (Inst_Req_Valid),
        .Inst_Req_Ack   (Inst_Req_Ack),
        .Instruction    (Instruction),
        .Inst_Valid     (Inst_Valid),
        .Inst_Ack       (Inst_Ack),
        .fence_i        (fence_i),
        .Mem_Req_Addr   (Mem_Req_Addr),
        .Mem_Req_Valid  (Mem_Req_Valid),
        .Mem_Req_Ready  (Mem_Req_Ready),
        .Mem_Rd_Data    (Mem_Rd_Data),
        .Mem_Rd_Valid   (Mem_Rd_Valid),
        .Mem_Rd_Last    (Mem_Rd_Last),
        .Mem_Rd_Ready   (Mem_Rd_Ready),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .refill_err     (refill_err)
    );

    int cmp_n  = 0;
    int fail_n = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int          req_cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mreq_q [$];

    // Reference model: 8 sets of 16-byte lines, tag = addr / 128
    logic [31:0] m_tag [8];
    bit          m_vld [8];
    int          m_hit, m_miss;
    bit          m_err;

    // Shared bench state
    int          resp_cnt = 0;
    int          ack_delay = 0;
    int          req_stall = 0;
    bit          err_next = 0;
    int          last_beat_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_n++;
        if (act !== req) begin
            fail_n++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        cmp_n++;
        fail_n++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'h10) return 32'hA0 + (w >> 2);
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 8; s++) m_vld[s] = 0;
    endtask

    // Returns 1 on a predicted hit, installs the line on a miss.
    function automatic bit model_access(input logic [31:0] a);
        int          s;
        logic [31:0] t;
        s = int'((a >> 4) % 8);
        t = a >> 7;
        if (m_vld[s] && m_tag[s] == t) begin
            m_hit++;
            return 1;
        end
        m_miss++;
        m_vld[s] = 1;
        m_tag[s] = t;
        return 0;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_hit_cnt"},    hit_cnt,    32'(m_hit));
        check({tag, "_miss_cnt"},   miss_cnt,   32'(m_miss));
        check({tag, "_refill_err"}, {31'd0, refill_err}, {31'd0, m_err});
    endtask

    // Issue one fetch, record expectations at the handshake, wait for response.
    task automatic fetch(input logic [31:0] a);
        bit   got;
        bit   h;
        int   target;
        exp_t e;
        PC = a;
        Inst_Req_Valid = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (Inst_Req_Ack) got = 1;
        end
        if (!got) begin
            fail_now("req_ack_timeout");
            Inst_Req_Valid = 1'b0;
            return;
        end
        h = model_access(a);
        e.data = mem_word(a);
        e.hit = h;
        e.req_cyc = cyc;
        target = resp_cnt + 1;
        exp_q.push_back(e);
        if (!h) mreq_q.push_back({a[31:4], 4'h0});
        @(posedge clk);
        #1;
        Inst_Req_Valid = 1'b0;
        PC = $urandom;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #2;
            if (resp_cnt >= target) got = 1;
        end
        if (!got) fail_now("response_timeout");
        else check_counters("fetch");
    endtask

    task automatic fence_idle();
        fence_i = 1'b1;
        @(negedge clk);
        check("fence_blocks_ack", {31'd0, Inst_Req_Ack}, 32'd0);
        @(posedge clk);
        #1;
        fence_i = 1'b0;
        model_clear();
    endtask

    // Memory responder: checks refill requests, returns bursts with gaps.
    bit          busy = 0;
    int          beat_i = 0;
    logic [31:0] base = 0;
    bit          req_seen = 0;
    logic [31:0] held_addr = 0;
    bit          err_this = 0;

    initial begin
        Mem_Req_Ready = 1'b0;
        Mem_Rd_Valid  = 1'b0;
        Mem_Rd_Data   = '0;
        Mem_Rd_Last   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0;
                req_seen = 0;
            end else begin
                if (busy && Mem_Rd_Valid && Mem_Rd_Ready) begin
                    beat_i++;
                    if (beat_i == 4) begin
                        busy = 0;
                        last_beat_cyc = cyc;
                    end
                end
                if (Mem_Req_Valid) begin
                    if (req_seen) check("mem_req_addr_stable", Mem_Req_Addr, held_addr);
                    else begin
                        req_seen = 1;
                        held_addr = Mem_Req_Addr;
                    end
                    if (Mem_Req_Ready) begin
                        if (mreq_q.size() == 0) fail_now("unexpected_mem_req");
                        else check("mem_req_addr", Mem_Req_Addr, mreq_q.pop_front());
                        busy = 1;
                        beat_i = 0;
                        base = Mem_Req_Addr;
                        req_seen = 0;
                        err_this = err_next;
                        err_next = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
            Mem_Req_Ready = (req_stall > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (req_stall > 0 && Mem_Req_Valid) req_stall--;
            Mem_Rd_Valid = busy && ($urandom_range(0, 2) != 0);
            Mem_Rd_Data  = Mem_Rd_Valid ? mem_word(base + 32'(4 * beat_i)) : $urandom;
            Mem_Rd_Last  = err_this ? (beat_i == 1 || beat_i == 3) : (beat_i == 3);
        end
    end

    // Core-side monitor: pops the scoreboard on each response handshake.
    bit          seen = 0;
    int          first_cyc = 0;
    logic [31:0] held_instr = 0;
    int          wait_cnt = 0;
    exp_t        pe;

    initial begin
        Inst_Ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && Inst_Valid) begin
                if (!seen) begin
                    seen = 1;
                    first_cyc = cyc;
                    held_instr = Instruction;
                    if (exp_q.size() > 0) begin
                        if (exp_q[0].hit) check("hit_latency", 32'(first_cyc - exp_q[0].req_cyc), 32'd2);
                        else check("miss_latency", 32'(first_cyc), 32'(last_beat_cyc + 1));
                    end
                end else begin
                    check("instr_stable", Instruction, held_instr);
                end
                if (Inst_Ack) begin
                    if (exp_q.size() == 0) fail_now("unexpected_response");
                    else begin
                        pe = exp_q.pop_front();
                        check("instruction", Instruction, pe.data);
                    end
                    resp_cnt++;
                    seen = 0;
                end
            end else begin
                seen = 0;
            end
            @(posedge clk);
            #1;
            if (Inst_Valid) begin
                wait_cnt++;
                Inst_Ack = (wait_cnt > ack_delay);
            end else begin
                wait_cnt = 0;
                Inst_Ack = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ack"},     {31'd0, Inst_Req_Ack},  32'd0);
        check({tag, "_inst_valid"},  {31'd0, Inst_Valid},    32'd0);
        check({tag, "_mem_req_vld"}, {31'd0, Mem_Req_Valid}, 32'd0);
        check({tag, "_mem_rd_rdy"},  {31'd0, Mem_Rd_Ready},  32'd0);
        check({tag, "_instruction"}, Instruction,  32'd0);
        check({tag, "_mem_req_addr"}, Mem_Req_Addr, 32'd0);
    endtask

    task automatic model_reset();
        model_clear();
        m_hit = 0;
        m_miss = 0;
        m_err = 0;
        exp_q.delete();
        mreq_q.delete();
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        PC = '0;
        Inst_Req_Valid = 1'b0;
        fence_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check_counters("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, then hit in the refilled line
        fetch(32'h0000_0008);
        fetch(32'h0000_000C);

        // Conflict eviction in set 0
        fetch(32'h0000_0080);
        fetch(32'h0000_0000);

        // Backpressure on request and response
        req_stall = 5;
        ack_delay = 3;
        fetch(32'h0000_0204);
        ack_delay = 0;

        // fence in IDLE together with a request: fence wins
        PC = 32'h0000_000C;
        Inst_Req_Valid = 1'b1;
        fence_idle();
        fetch(32'h0000_000C);

        // fence during refill: fetch completes, line then gone
        fork
            fetch(32'h0000_0300);
            begin
                got = 0;
                for (int i = 0; i < 200 && !got; i++) begin
                    @(negedge clk);
                    if (Mem_Rd_Ready) got = 1;
                end
                if (!got) fail_now("refill_wait_timeout");
                @(posedge clk);
                #1;
                fence_i = 1'b1;
                @(posedge clk);
                #1;
                fence_i = 1'b0;
            end
        join
        model_clear();
        fetch(32'h0000_0300);

        // Early Last on beat 1
        err_next = 1;
        m_err = 1;
        fetch(32'h0000_0408);

        // Randomized traffic over 4 tags x 8 sets
        for (int n = 0; n < 80; n++) begin
            ack_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) req_stall = $urandom_range(1, 4);
            if ($urandom_range(0, 11) == 0) fence_idle();
            fetch(32'($urandom_range(0, 127) * 4));
        end
        ack_delay = 0;

        // Reset in the middle of a refill
        fence_idle();
        PC = 32'h0000_0044;
        Inst_Req_Valid = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (Inst_Req_Ack) got = 1;
        end
        if (!got) fail_now("reset_test_ack_timeout");
        mreq_q.push_back(32'h0000_0040);
        @(posedge clk);
        #1;
        Inst_Req_Valid = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (Mem_Rd_Ready) got = 1;
        end
        if (!got) fail_now("reset_test_refill_timeout");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        model_reset();
        check_counters("midreset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        fetch(32'h0000_0044);
        fetch(32'h0000_0048);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) fail_now("responses_missing");
        if (mreq_q.size() != 0) fail_now("refills_missing");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
